// File: rtl/arbitro_memoria.sv
// arbitro_memoria: single-port arbiter for the two board RAMs, shared by
// VGA, validador and colisor, with round-robin val/col and an RMW lock.
module arbitro_memoria #(
  parameter int ROWS    = 11,
  parameter int RD_LAT  = 2,
  parameter int LOCK_TO = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_req,
  input  logic        vga_player,
  input  logic [4:0]  vga_addr,
  output logic        vga_gnt,
  output logic        vga_rvalid,
  input  logic        val_req,
  input  logic        val_we,
  input  logic        val_lock,
  input  logic        val_player,
  input  logic [4:0]  val_addr,
  input  logic [63:0] val_wdata,
  output logic        val_gnt,
  output logic        val_rvalid,
  input  logic        col_req,
  input  logic        col_we,
  input  logic        col_lock,
  input  logic        col_player,
  input  logic [4:0]  col_addr,
  input  logic [63:0] col_wdata,
  output logic        col_gnt,
  output logic        col_rvalid,
  output logic [63:0] rd_data,
  output logic        addr_err,
  output logic [4:0]  addr_memoria,
  output logic        wren_p1,
  output logic        wren_p2,
  output logic [63:0] data_memoria_salvar,
  input  logic [63:0] data_memoria_um,
  input  logic [63:0] data_memoria_dois,
  output logic        busy
);

  localparam int LW = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_TO - 1);
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);
  localparam logic [5:0] ROWS_L = 6'(ROWS);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR} state_t;
  typedef enum logic [1:0] {SRC_VGA, SRC_VAL, SRC_COL} src_t;

  state_t        state;
  src_t          cur_src;
  logic [2:0]    cnt;
  logic          reg_player;
  logic          reg_oob;
  logic          lock_on;
  logic          lock_col;
  logic [LW-1:0] lock_cnt;
  logic          rr_col;
  logic          last_vga;

  logic          pick_vga;
  logic          pick_val;
  logic          pick_col;
  logic          any_pick;
  logic          vc_req;
  logic          owner_req;
  logic          sel_player;
  logic [4:0]    sel_addr;
  logic          sel_we;
  logic          sel_lock;
  logic [63:0]   sel_wdata;
  logic          sel_oob;

  assign vc_req    = val_req | col_req;
  assign owner_req = lock_col ? col_req : val_req;
  assign any_pick  = pick_vga | pick_val | pick_col;
  assign sel_oob   = {1'b0, sel_addr} >= ROWS_L;
  assign busy      = (state != IDLE);

  // VGA yields once after its own grant so held val/col requests progress
  always_comb begin
    pick_vga = 1'b0;
    pick_val = 1'b0;
    pick_col = 1'b0;
    if (lock_on) begin
      pick_val = ~lock_col & val_req;
      pick_col = lock_col & col_req;
    end else if (vga_req && !(last_vga && vc_req)) begin
      pick_vga = 1'b1;
    end else if (val_req && (!col_req || !rr_col)) begin
      pick_val = 1'b1;
    end else if (col_req) begin
      pick_col = 1'b1;
    end
  end

  always_comb begin
    sel_player = vga_player;
    sel_addr   = vga_addr;
    sel_we     = 1'b0;
    sel_lock   = 1'b0;
    sel_wdata  = '0;
    unique case (1'b1)
      pick_val: begin
        sel_player = val_player;
        sel_addr   = val_addr;
        sel_we     = val_we;
        sel_lock   = val_lock;
        sel_wdata  = val_wdata;
      end
      pick_col: begin
        sel_player = col_player;
        sel_addr   = col_addr;
        sel_we     = col_we;
        sel_lock   = col_lock;
        sel_wdata  = col_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      cur_src             <= SRC_VGA;
      cnt                 <= '0;
      reg_player          <= 1'b0;
      reg_oob             <= 1'b0;
      lock_on             <= 1'b0;
      lock_col            <= 1'b0;
      lock_cnt            <= '0;
      rr_col              <= 1'b0;
      last_vga            <= 1'b0;
      vga_gnt             <= 1'b0;
      val_gnt             <= 1'b0;
      col_gnt             <= 1'b0;
      vga_rvalid          <= 1'b0;
      val_rvalid          <= 1'b0;
      col_rvalid          <= 1'b0;
      rd_data             <= '0;
      addr_err            <= 1'b0;
      addr_memoria        <= '0;
      wren_p1             <= 1'b0;
      wren_p2             <= 1'b0;
      data_memoria_salvar <= '0;
    end else begin
      vga_gnt    <= 1'b0;
      val_gnt    <= 1'b0;
      col_gnt    <= 1'b0;
      vga_rvalid <= 1'b0;
      val_rvalid <= 1'b0;
      col_rvalid <= 1'b0;
      addr_err   <= 1'b0;
      wren_p1    <= 1'b0;
      wren_p2    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lock_on && !owner_req) begin
            if (lock_cnt == LOCK_MAX) begin
              lock_on  <= 1'b0;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
          if (any_pick) begin
            vga_gnt      <= pick_vga;
            val_gnt      <= pick_val;
            col_gnt      <= pick_col;
            last_vga     <= pick_vga;
            reg_player   <= sel_player;
            reg_oob      <= sel_oob;
            addr_err     <= sel_oob;
            addr_memoria <= sel_addr;
            unique case (1'b1)
              pick_val: cur_src <= SRC_VAL;
              pick_col: cur_src <= SRC_COL;
              default:  cur_src <= SRC_VGA;
            endcase
            if (pick_val) rr_col <= 1'b1;
            if (pick_col) rr_col <= 1'b0;
            if (!pick_vga) begin
              lock_on  <= sel_lock;
              lock_col <= pick_col;
              lock_cnt <= '0;
            end
            if (sel_we) begin
              state               <= WR;
              data_memoria_salvar <= sel_wdata;
              wren_p1             <= ~sel_player & ~sel_oob;
              wren_p2             <= sel_player & ~sel_oob;
            end else begin
              state <= RD_WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        RD_WAIT: begin
          // the rvalid cycle still counts as part of the access
          if (vga_rvalid | val_rvalid | col_rvalid) begin
            state <= IDLE;
          end else if (cnt == 3'd0) begin
            if (reg_oob)
              rd_data <= '0;
            else if (reg_player)
              rd_data <= data_memoria_dois;
            else
              rd_data <= data_memoria_um;
            vga_rvalid <= (cur_src == SRC_VGA);
            val_rvalid <= (cur_src == SRC_VAL);
            col_rvalid <= (cur_src == SRC_COL);
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: directed stimulus with an expectation queue drained
// by a monitor on every gnt/rvalid the arbiter presents.
module tb_arbitro_memoria;

  localparam int RD_LAT = 2;
  localparam int LEN_RD = RD_LAT + 2;
  localparam int LEN_WR = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_req, vga_player;
  logic [4:0]  vga_addr;
  logic        vga_gnt, vga_rvalid;
  logic        val_req, val_we, val_lock, val_player;
  logic [4:0]  val_addr;
  logic [63:0] val_wdata;
  logic        val_gnt, val_rvalid;
  logic        col_req, col_we, col_lock, col_player;
  logic [4:0]  col_addr;
  logic [63:0] col_wdata;
  logic        col_gnt, col_rvalid;
  logic [63:0] rd_data;
  logic        addr_err;
  logic [4:0]  addr_memoria;
  logic        wren_p1, wren_p2;
  logic [63:0] data_memoria_salvar;
  logic [63:0] data_memoria_um, data_memoria_dois;
  logic        busy;

  arbitro_memoria #(
    .ROWS(11), .RD_LAT(RD_LAT), .LOCK_TO(8)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_player(vga_player),
    .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid),
    .val_req(val_req), .val_we(val_we),
    .val_lock(val_lock), .val_player(val_player),
    .val_addr(val_addr), .val_wdata(val_wdata),
    .val_gnt(val_gnt), .val_rvalid(val_rvalid),
    .col_req(col_req), .col_we(col_we),
    .col_lock(col_lock), .col_player(col_player),
    .col_addr(col_addr), .col_wdata(col_wdata),
    .col_gnt(col_gnt), .col_rvalid(col_rvalid),
    .rd_data(rd_data), .addr_err(addr_err),
    .addr_memoria(addr_memoria),
    .wren_p1(wren_p1), .wren_p2(wren_p2),
    .data_memoria_salvar(data_memoria_salvar),
    .data_memoria_um(data_memoria_um),
    .data_memoria_dois(data_memoria_dois),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // board RAMs: one registered read stage, default row i = 1000+i / 2000+i
  logic [63:0] mem1 [32];
  logic [63:0] mem2 [32];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= 64'h1000 + 64'(i);
        mem2[i] <= 64'h2000 + 64'(i);
      end
    end else begin
      if (wren_p1) mem1[addr_memoria] <= data_memoria_salvar;
      if (wren_p2) mem2[addr_memoria] <= data_memoria_salvar;
    end
    data_memoria_um   <= mem1[addr_memoria];
    data_memoria_dois <= mem2[addr_memoria];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  task automatic check_ge(input string name, input int act,
                          input int min);
    checks++;
    if (act >= min) passed++;
    else $display("FAIL %s: got %0d, want >= %0d", name, act, min);
  endtask

  typedef struct {
    int          who;
    bit          rv;
    logic [63:0] val;
    int          gap;
    int          len;
  } ev_t;

  ev_t expq[$];

  function automatic void exp_gnt(input int who, input logic p1,
                                  input logic p2, input logic err,
                                  input logic [4:0] a, input int len);
    ev_t e;
    e.who = who;
    e.rv  = 1'b0;
    e.val = 64'({p1, p2, err, a});
    e.gap = 0;
    e.len = len;
    expq.push_back(e);
  endfunction

  function automatic void exp_rv(input int who, input logic [63:0] d);
    ev_t e;
    e.who = who;
    e.rv  = 1'b1;
    e.val = d;
    e.gap = RD_LAT;
    e.len = 0;
    expq.push_back(e);
  endfunction

  logic [2:0] gnts, rvs;
  assign gnts = {col_gnt, val_gnt, vga_gnt};
  assign rvs  = {col_rvalid, val_rvalid, vga_rvalid};

  ev_t me;
  int  last_gnt = -1;
  int  last_len = 0;
  int  gcyc [3];

  always @(negedge clk) begin
    if (reset) begin
      for (int w = 0; w < 3; w++) begin
        if (gnts[w]) begin
          if (expq.size() == 0) begin
            check("unexpected gnt", 64'(w), 64'hFF);
          end else begin
            me = expq.pop_front();
            check("gnt order", 64'(w * 2),
                  64'(me.who * 2 + int'(me.rv)));
            check("gnt bus", 64'({wren_p1, wren_p2, addr_err,
                                  addr_memoria}), me.val);
            if (last_gnt >= 0)
              check_ge("gnt spacing", cyc - last_gnt, last_len);
            last_gnt = cyc;
            last_len = me.len;
            gcyc[w]  = cyc;
          end
        end
        if (rvs[w]) begin
          if (expq.size() == 0) begin
            check("unexpected rvalid", 64'(w), 64'hFF);
          end else begin
            me = expq.pop_front();
            check("rvalid order", 64'(w * 2 + 1),
                  64'(me.who * 2 + int'(me.rv)));
            check("rd_data", rd_data, me.val);
            check("read latency", 64'(cyc - gcyc[w]), 64'(me.gap));
          end
        end
      end
    end
  end

  task automatic wait_out(input int w, input bit rv, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      seen = rv ? rvs[w] : gnts[w];
    end
    if (!seen) check(rv ? "rvalid timeout" : "gnt timeout", 64'(w), 64'hFF);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  int t0, t1, n;

  initial begin
    reset = 1'b0;
    {vga_req, vga_player, vga_addr} = '0;
    {val_req, val_we, val_lock, val_player, val_addr, val_wdata} = '0;
    {col_req, col_we, col_lock, col_player, col_addr, col_wdata} = '0;
    repeat (3) @(negedge clk);
    check("reset gnt/rvalid", 64'({vga_gnt, val_gnt, col_gnt,
          vga_rvalid, val_rvalid, col_rvalid}), 64'h0);
    check("reset wren/err/busy", 64'({wren_p1, wren_p2, addr_err, busy}),
          64'h0);
    check("reset addr_memoria", 64'(addr_memoria), 64'h0);
    check("reset wdata bus", data_memoria_salvar, 64'h0);
    check("reset rd_data", rd_data, 64'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // val write row 3 player 2
    exp_gnt(1, 1'b0, 1'b1, 1'b0, 5'd3, LEN_WR);
    {val_req, val_we, val_lock, val_player} = 4'b1101;
    val_addr  = 5'd3;
    val_wdata = 64'hA5;
    wait_out(1, 1'b0, 20);
    val_req = 1'b0;
    check("write busy", 64'(busy), 64'h1);
    check("write data bus", data_memoria_salvar, 64'hA5);
    @(negedge clk);
    check("write busy end", 64'(busy), 64'h0);
    check("write wren end", 64'({wren_p1, wren_p2}), 64'h0);

    // VGA read back
    exp_gnt(0, 1'b0, 1'b0, 1'b0, 5'd3, LEN_RD);
    exp_rv(0, 64'hA5);
    {vga_req, vga_player, vga_addr} = {1'b1, 1'b1, 5'd3};
    wait_out(0, 1'b0, 20);
    vga_req = 1'b0;
    wait_out(0, 1'b1, 20);

    // three held requesters from a fresh arbiter
    do_reset();
    exp_gnt(0, 1'b0, 1'b0, 1'b0, 5'd2, LEN_RD);
    exp_rv(0, 64'h1002);
    exp_gnt(1, 1'b1, 1'b0, 1'b0, 5'd1, LEN_WR);
    exp_gnt(0, 1'b0, 1'b0, 1'b0, 5'd2, LEN_RD);
    exp_rv(0, 64'h1002);
    exp_gnt(2, 1'b0, 1'b1, 1'b0, 5'd4, LEN_WR);
    exp_gnt(0, 1'b0, 1'b0, 1'b0, 5'd2, LEN_RD);
    exp_rv(0, 64'h1002);
    exp_gnt(1, 1'b1, 1'b0, 1'b0, 5'd1, LEN_WR);
    {vga_req, vga_player, vga_addr} = {1'b1, 1'b0, 5'd2};
    {val_req, val_we, val_lock, val_player} = 4'b1100;
    val_addr  = 5'd1;
    val_wdata = 64'h11;
    {col_req, col_we, col_lock, col_player} = 4'b1101;
    col_addr  = 5'd4;
    col_wdata = 64'h22;
    n = 0;
    for (int i = 0; i < 80 && n < 6; i++) begin
      @(negedge clk);
      if (|gnts) n++;
    end
    {vga_req, val_req, col_req} = 3'b000;
    check("contention grants", 64'(n), 64'd6);
    repeat (3) @(negedge clk);

    // locked read-modify-write by col, VGA waiting
    exp_gnt(2, 1'b0, 1'b0, 1'b0, 5'd5, LEN_RD);
    exp_rv(2, 64'h1005);
    exp_gnt(2, 1'b1, 1'b0, 1'b0, 5'd5, LEN_WR);
    exp_gnt(0, 1'b0, 1'b0, 1'b0, 5'd5, LEN_RD);
    exp_rv(0, 64'h10FA);
    {col_req, col_we, col_lock, col_player} = 4'b1010;
    col_addr = 5'd5;
    wait_out(2, 1'b0, 20);
    t0 = cyc;
    col_req = 1'b0;
    {vga_req, vga_player, vga_addr} = {1'b1, 1'b0, 5'd5};
    wait_out(2, 1'b1, 20);
    {col_req, col_we, col_lock} = 3'b110;
    col_wdata = 64'h10FA;
    wait_out(2, 1'b0, 20);
    t1 = cyc;
    col_req = 1'b0;
    check("rmw write gnt delay", 64'(t1 - t0), 64'd4);
    wait_out(0, 1'b0, 20);
    vga_req = 1'b0;
    check("vga after unlock", 64'(cyc - t1), 64'd2);
    wait_out(0, 1'b1, 20);
    @(negedge clk);

    // val locks then walks away
    exp_gnt(1, 1'b1, 1'b0, 1'b0, 5'd6, LEN_WR);
    exp_gnt(0, 1'b0, 1'b0, 1'b0, 5'd6, LEN_RD);
    exp_rv(0, 64'h66);
    {val_req, val_we, val_lock, val_player} = 4'b1110;
    val_addr  = 5'd6;
    val_wdata = 64'h66;
    wait_out(1, 1'b0, 20);
    t0 = cyc;
    {val_req, val_lock} = 2'b00;
    {vga_req, vga_player, vga_addr} = {1'b1, 1'b0, 5'd6};
    wait_out(0, 1'b0, 40);
    vga_req = 1'b0;
    check("lock timeout grant", 64'(cyc - t0), 64'd10);
    wait_out(0, 1'b1, 20);
    @(negedge clk);

    // out-of-range row 11
    exp_gnt(1, 1'b0, 1'b0, 1'b1, 5'd11, LEN_WR);
    exp_gnt(0, 1'b0, 1'b0, 1'b1, 5'd11, LEN_RD);
    exp_rv(0, 64'h0);
    {val_req, val_we, val_lock, val_player} = 4'b1100;
    val_addr  = 5'd11;
    val_wdata = 64'hBAD;
    wait_out(1, 1'b0, 20);
    val_req = 1'b0;
    @(negedge clk);
    check("addr_err one cycle", 64'(addr_err), 64'h0);
    {vga_req, vga_player, vga_addr} = {1'b1, 1'b0, 5'd11};
    wait_out(0, 1'b0, 20);
    vga_req = 1'b0;
    wait_out(0, 1'b1, 20);
    check("oob write kept ram", mem1[11], 64'h100B);
    @(negedge clk);

    // reset in the middle of a read
    exp_gnt(0, 1'b0, 1'b0, 1'b0, 5'd3, LEN_RD);
    {vga_req, vga_player, vga_addr} = {1'b1, 1'b1, 5'd3};
    wait_out(0, 1'b0, 20);
    vga_req = 1'b0;
    @(negedge clk);
    check("mid read busy", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    check("async reset flags", 64'({vga_gnt, val_gnt, col_gnt,
          vga_rvalid, val_rvalid, col_rvalid, wren_p1, wren_p2,
          addr_err, busy}), 64'h0);
    check("async reset addr", 64'(addr_memoria), 64'h0);
    check("async reset wdata", data_memoria_salvar, 64'h0);
    check("async reset rd_data", rd_data, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (|rvs) n++;
    end
    check("no rvalid after reset", 64'(n), 64'h0);

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    check("pending expectations", 64'(expq.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Single-port arbiter and sequencer for the two player board memories (one 64-bit row per address, player 1 and player 2). It shares the memory address and write bus between three requesters: the VGA renderer (read only), the placement validator (validador) and the shot collision checker (colisor). Validator and colisor can do atomic read-modify-write through a lock. The block sits between those three units and the board RAMs inside the top-level game module.

## Interface
Parameters:
- ROWS, 11: valid row addresses are 0..ROWS-1.
- RD_LAT, 2: RAM read latency in clocks, from the address being driven to the data being valid. Legal range 1..7.
- LOCK_TO, 8: clocks a lock is held while its owner has no request.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- vga_req, vga_player, vga_addr[4:0]  in  VGA read request; player 0 selects player 1 RAM, player 1 selects player 2 RAM
- vga_gnt, vga_rvalid  out  1 each
- val_req, val_we, val_lock, val_player  in  1 each; val_addr in 5; val_wdata in 64
- val_gnt, val_rvalid  out  1 each
- col_req, col_we, col_lock, col_player  in  1 each; col_addr in 5; col_wdata in 64
- col_gnt, col_rvalid  out  1 each
- rd_data  out  64  read data, shared by all requesters, qualified by each requester's rvalid
- addr_err  out  1  one-cycle pulse when a granted address is ≥ ROWS
- addr_memoria  out  5; wren_p1, wren_p2  out  1; data_memoria_salvar  out  64
- data_memoria_um, data_memoria_dois  in  64  RAM read ports for player 1 and player 2
- busy  out  1  high whenever the state is not IDLE

## Operation
State machine: IDLE, RD_WAIT, WR.

IDLE arbitration, evaluated at each edge:
- If a lock is active, only the lock owner is eligible.
- Otherwise vga_req has highest priority.
- val and col then share round-robin. The loser of the last val/col contest wins the next one. Reset favours val.

Grant:
- The granted request's player, addr, we and wdata are captured into registers.
- The matching gnt is high for exactly the following cycle.
- VGA requests are always reads; vga_we does not exist.

Write (we=1):
- The state goes to WR for one cycle.
- addr_memoria = addr and data_memoria_salvar = wdata.
- wren_p1 = ~player or wren_p2 = player; never both.
- The state then returns to IDLE.

Read (we=0):
- addr_memoria is driven; the state goes to RD_WAIT.
- A counter runs from RD_LAT-1 down to 0.
- At the edge where the counter reaches 0, rd_data captures data_memoria_um (player 0) or data_memoria_dois (player 1).
- The owner's rvalid is high for the next cycle, and the state returns to IDLE.

Lock:
- A granted val or col transaction with lock=1 reserves arbitration for that same requester.
- The lock clears on the owner's next grant that has lock=0.
- The lock also clears after LOCK_TO consecutive IDLE cycles in which the owner has no req.
- VGA is blocked while a lock is active.

Out-of-range address (addr ≥ ROWS):
- The request is still granted.
- Writes are suppressed: wren stays 0.
- Reads complete with rd_data = 0 on the normal schedule.
- addr_err pulses in the gnt cycle.

Other rules:
- rd_data holds its value between reads.
- addr_memoria and data_memoria_salvar hold their last values.
- wren_p1 and wren_p2 are high only in WR.

Requester rule: req, addr, we, wdata, player and lock must stay stable until gnt is seen. The requester may present its next request or drop req in the gnt cycle.

## Timing
- Reset (asynchronous, reset=0) puts every output at 0:
  - gnt, rvalid, wren_p1, wren_p2, addr_err and busy are 0.
  - addr_memoria, data_memoria_salvar and rd_data are 0.
  - The state is IDLE, the lock is cleared and the round-robin pointer favours val.
- An in-flight read is dropped with no rvalid. wren falls immediately.
- Request seen at edge E0:
  - gnt is high in cycle E0..E0+1.
  - A write has wren high in that same cycle.
  - A read has rvalid high in cycle E0+RD_LAT..E0+RD_LAT+1.
- Throughput:
  - One write every 2 cycles: next grant at E0+2 at the earliest.
  - One read every RD_LAT+2 cycles.
  - A locked read-modify-write with RD_LAT=2 has its write gnt at E0+4 at the earliest.
- Simultaneous requests: one grant per arbitration. Losers keep req and are not acknowledged.
- A requester's req dropped before its gnt is treated as withdrawn.

## Test plan
- Reset, then a val write: row 3, player 1, 64'hA5. Required: val_gnt and wren_p2 in the same single cycle, addr_memoria=3, wren_p1 stays 0, busy for 1 cycle.
- VGA read of row 3, player 1, with RD_LAT=2 and the RAM model returning 64'hA5. Required: vga_rvalid exactly 2 cycles after gnt with rd_data=64'hA5.
- vga, val and col requesting together and held. Required grant order: vga, val, vga, col, vga, val, … with no two grants closer than the access length.
- col read with lock=1, then col write to the same row with lock=0, with vga requesting throughout. Required: no vga_gnt between the col read and the col write; vga granted right after the write.
- val locks and then drops req. Required: the lock releases after 8 idle cycles and the pending vga_req is granted on the next edge.
- Edge cases:
  - A write to row 11 (ROWS=11): addr_err pulse and no wren.
  - Reset asserted during RD_WAIT: no rvalid, and all outputs 0 immediately.
